// File: rtl/frame_compositor_pkg.sv
// Shared types for the frame compositor: FSM states, matrix size and the 8x8 frame type.
package compositor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    BLINK = 2'd2,
    HOLD  = 2'd3
  } comp_state_t;

  localparam int DIM = 8;

  typedef logic [DIM-1:0][DIM-1:0] frame_t;

  function automatic logic is_frozen(input comp_state_t s);
    return (s == BLINK) || (s == HOLD);
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Counts frame ticks into blink half-periods; phase starts off and flips each half-period,
// done latches once the configured number of half-periods has elapsed.
module blink_timer #(
  parameter int BLINK_TICKS = 4,
  parameter int BLINK_COUNT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic phase,
  output logic done
);

  localparam int TW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int HW = $clog2(2 * BLINK_COUNT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(BLINK_TICKS - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * BLINK_COUNT);

  logic [TW-1:0] tick_cnt_r;
  logic [HW-1:0] half_cnt_r;
  logic          phase_r;
  logic          done_r;
  logic          wrap_s;

  assign wrap_s = tick && (tick_cnt_r == TICK_LAST);
  assign phase  = phase_r;
  assign done   = done_r;

  // Tick counter, saturating half-period counter, phase and done flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_r <= '0;
      half_cnt_r <= '0;
      phase_r    <= 1'b0;
      done_r     <= 1'b0;
    end else if (clear) begin
      tick_cnt_r <= '0;
      half_cnt_r <= '0;
      phase_r    <= 1'b0;
      done_r     <= 1'b0;
    end else if (wrap_s) begin
      tick_cnt_r <= '0;
      phase_r    <= ~phase_r;
      if (half_cnt_r != HALF_LAST) begin
        half_cnt_r <= half_cnt_r + HW'(1);
      end else begin
        half_cnt_r <= half_cnt_r;
      end
      done_r <= done_r | (half_cnt_r >= (HALF_LAST - HW'(1)));
    end else if (tick) begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

endmodule

// File: rtl/frame_compositor.sv
// Snapshots the live red/green layers on each frame tick and, after game over,
// freezes the last frame, blinks the bird (red) layer, then holds until restart.
module frame_compositor
  import compositor_pkg::*;
#(
  parameter int BLINK_TICKS = 4,
  parameter int BLINK_COUNT = 3
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   tick,
  input  logic   start,
  input  logic   over,
  input  frame_t red_in,
  input  frame_t green_in,
  output frame_t red_array,
  output frame_t green_array,
  output logic   frozen
);

  comp_state_t state_r, next_state_s;
  frame_t      snap_red_r, snap_green_r;
  frame_t      red_next_s, green_next_s;
  logic        capture_s, frozen_next_s, timer_clear_s;
  logic        phase_s, done_s;

  blink_timer #(
    .BLINK_TICKS(BLINK_TICKS),
    .BLINK_COUNT(BLINK_COUNT)
  ) u_blink_timer (
    .clk  (clk),
    .reset(reset),
    .clear(timer_clear_s),
    .tick (tick),
    .phase(phase_s),
    .done (done_s)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a dropped start always wins over blink completion
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (start) next_state_s = PLAY;  else next_state_s = IDLE;
      PLAY:    if (over)  next_state_s = BLINK; else next_state_s = PLAY;
      BLINK: begin
        if (!start)      next_state_s = IDLE;
        else if (done_s) next_state_s = HOLD;
        else             next_state_s = BLINK;
      end
      HOLD:    if (!start) next_state_s = IDLE; else next_state_s = HOLD;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode; done masks the trailing off-phase so HOLD follows an on half-period cleanly
  always_comb begin
    capture_s     = 1'b0;
    red_next_s    = snap_red_r;
    green_next_s  = snap_green_r;
    frozen_next_s = is_frozen(state_r);
    timer_clear_s = (state_r != BLINK);
    case (state_r)
      IDLE: capture_s = tick;
      PLAY: capture_s = tick && !over;
      BLINK: begin
        if (!phase_s && !done_s) red_next_s = '0;
        else                     red_next_s = snap_red_r;
      end
      HOLD:    capture_s = 1'b0;
      default: capture_s = 1'b0;
    endcase
  end

  // Frame snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_red_r   <= '0;
      snap_green_r <= '0;
    end else if (capture_s) begin
      snap_red_r   <= red_in;
      snap_green_r <= green_in;
    end else begin
      snap_red_r   <= snap_red_r;
      snap_green_r <= snap_green_r;
    end
  end

  // Registered outputs to the matrix driver
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_array   <= '0;
      green_array <= '0;
      frozen      <= 1'b0;
    end else begin
      red_array   <= red_next_s;
      green_array <= green_next_s;
      frozen      <= frozen_next_s;
    end
  end

endmodule

// File: doc/frame_compositor.md
# frame_compositor

Registered frame stage between the game logic (bird column, pipe scroller, game-over detector) and `led_matrix_driver`. On each frame tick it captures the live 8×8 red and green arrays into a snapshot. This keeps the scanned image tear-free while the game logic updates mid-scan. When `over` asserts, the block freezes the final frame, blinks the bird layer a fixed number of times, then holds the frozen frame until the game is restarted.

## Interface
Parameters:
- `BLINK_TICKS`, default 4: frame ticks per blink half-period (≥1).
- `BLINK_COUNT`, default 3: number of full off/on blinks after game over (≥1).

Ports:
- `clk` input, 1: single system clock (the game-rate clock).
- `reset` input, 1: **asynchronous, active-high** reset.
- `tick` input, 1: one-cycle frame strobe.
- `start` input, 1: game running (level).
- `over` input, 1: game over (level, from the game-over detector).
- `red_in` input, 8×8 packed `[7:0][7:0]`: live bird layer.
- `green_in` input, 8×8 packed: live pipe layer.
- `red_array` output, 8×8 packed: composited red layer to the matrix driver.
- `green_array` output, 8×8 packed: composited green layer to the matrix driver.
- `frozen` output, 1: high while in BLINK or HOLD.

## Operation
- Snapshot registers `snap_r` and `snap_g` are 64 bits each. Outputs are derived from the snapshot and the current state, and are registered.
- States:
  - **IDLE**: waiting for play to begin.
    - On `tick`, capture inputs.
    - Go to PLAY when `start`=1.
  - **PLAY**: normal play.
    - On `tick`, capture inputs.
    - Go to BLINK when `over`=1.
  - **BLINK**: no capture.
    - Phase bit toggles every `BLINK_TICKS` ticks, starting in the off phase.
    - In the off phase, `red_array`=0 and `green_array`=`snap_g`. In the on phase, both layers show the snapshot.
    - After 2·`BLINK_COUNT` half-periods, go to HOLD.
  - **HOLD**: outputs show the snapshot. No capture.
- Exit from the frozen states: `start`=0 in BLINK or HOLD moves to IDLE on the next edge, clears the blink counters, and resumes capture.
- In IDLE and PLAY, outputs are `snap_r` and `snap_g` unmodified.
- Priority when `over` rises in the same cycle as `tick`: `over` wins. The snapshot keeps the previous frame and no capture occurs.
- `over`=1 while in IDLE is ignored. BLINK is only reachable from PLAY.
- Counters:
  - The tick counter is `$clog2(BLINK_TICKS)` bits wide and wraps to 0 at `BLINK_TICKS`-1.
  - The half-period counter is `$clog2(2*BLINK_COUNT+1)` bits wide and saturates.

## Timing
- Reset (asynchronous) sets: state=IDLE, snapshots=0, counters=0, phase=off, `red_array`=0, `green_array`=0, `frozen`=0.
- Capture latency: `tick` at edge N makes `red_in`/`green_in` visible on the outputs after edge N+1 (one register for the snapshot, one for the output).
- `frozen` rises one cycle after the PLAY→BLINK edge and falls one cycle after the →IDLE edge.
- Blink start: the red layer goes dark within 2 cycles of `over` being sampled high.
- Blink length: the red layer toggles exactly 2·`BLINK_COUNT` times, at tick boundaries, before HOLD.
- Reset asserted mid-blink clears everything immediately, without waiting for a clock edge.
- `tick` held high for multiple cycles counts one tick per cycle. This is legal but not expected.

## Structure
- Package `compositor_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, PLAY, BLINK, HOLD} comp_state_t`
  - `localparam DIM = 8`
  - `typedef logic [DIM-1:0][DIM-1:0] frame_t`
- Sub-module `blink_timer` (clk, reset, clear, tick → phase, done) holds the tick counter, half-period counter and phase bit. The top module holds the FSM, snapshots and output mux.

## Test plan
1. **Reset:** assert `reset` asynchronously mid-cycle → all outputs 0 and `frozen`=0 before the next edge.
2. **Capture:** in IDLE, set `red_in[0]`=8'h10 and `green_in[7]`=8'hE7, pulse `tick` → both values appear on the outputs 2 edges later. Changing the inputs without a `tick` does not change the outputs.
3. **Blink sequence:** with defaults, go PLAY → `over`=1, then 24 ticks.
   - Expected: `red_array[0]` reads 0 for 4 ticks, then 8'h10 for 4 ticks, repeated 3 times, then stays 8'h10 in HOLD.
   - `green_array` is constant throughout and `frozen`=1.
4. **Simultaneous over and tick:** `tick` and `over` rise together with `red_in` changed → the snapshot keeps the old frame.
5. **Restart:** in HOLD, drop `start` → next edge IDLE, `frozen`=0, and the next `tick` captures new inputs. Dropping `start` mid-blink also returns to IDLE with the blink counters cleared.
6. **Ignored over:** `over`=1 while in IDLE with `start`=0 → no blinking and `frozen` stays 0.
